// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//
// Store-and-forward frame parser sitting behind a UART RX FIFO. Pops bytes from
// the FIFO, hunts for a start-of-frame byte, collects a length-prefixed payload,
// checks an 8-bit additive checksum and, only for a good frame, streams the
// payload out on a valid/ready byte interface. Bad frames are dropped and
// reported through frame_err/err_code.
//
// Frame: SOF, LEN (1..MAX_LEN), LEN payload bytes, CHK = (LEN + sum(payload)) mod 256.
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to enable the inter-byte
// timeout (err_code 11). Without it a partial frame waits indefinitely.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rx_empty   UART RX FIFO empty
//   r_data     UART RX FIFO data, valid the cycle after rd_uart
//   rd_uart    single-cycle FIFO pop
//   out_data   payload byte
//   out_valid  out_data valid
//   out_ready  consumer ready; byte transfers on out_valid & out_ready
//   out_last   final payload byte, qualified by out_valid
//   frame_ok   one-cycle pulse, good frame accepted
//   frame_err  one-cycle pulse, frame discarded
//   err_code   01 bad length, 10 bad checksum, 11 timeout; held until next error
//   frame_len  LEN of the last good frame
module uart_frame_parser #(
  parameter int unsigned        MAX_LEN        = 16,
  parameter logic [7:0]         SOF            = 8'hA5,
  parameter int unsigned        TO_BITS        = 20,
  parameter logic [TO_BITS-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_len
);

  localparam int unsigned IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLen = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    StHunt,
    StLen,
    StPayload,
    StChk,
    StDrain
  } state_e;

  state_e     state_q, state_d;
  logic       rd_q, rd_d;
  logic       cap_q;          // r_data holds a freshly popped byte this cycle
  logic [7:0] len_q, len_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic [1:0] err_code_q, err_code_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic       buf_we;
  logic       timeout;
  logic       drain_last;

  logic [7:0] buf_q [MAX_LEN];

  assign drain_last = (idx_q == len_q - 8'd1);

  // Inter-byte timeout
`ifdef UART_FRAME_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;

  // The error fires on the cycle after the TIMEOUT_CYCLES-th idle cycle.
  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if ((state_q == StLen || state_q == StPayload || state_q == StChk) && !cap_q) begin
      if (to_cnt_q + 1'b1 == TIMEOUT_CYCLES) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;

  logic unused_to_cfg;
  assign unused_to_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    frame_len_d = frame_len_q;
    err_code_d  = err_code_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (cap_q && r_data == SOF) begin
          acc_d   = 8'h00;
          state_d = StLen;
        end
      end
      StLen: begin
        if (cap_q) begin
          if (r_data == 8'h00 || r_data > MaxLen) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
            state_d     = StHunt;
          end else begin
            len_d   = r_data;
            acc_d   = r_data;
            idx_d   = 8'h00;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        // SOF-valued bytes are plain data here.
        if (cap_q) begin
          buf_we = 1'b1;
          acc_d  = acc_q + r_data;
          idx_d  = idx_q + 8'd1;
          if (drain_last) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (cap_q) begin
          if (r_data == acc_q) begin
            frame_ok_d  = 1'b1;
            frame_len_d = len_q;
            idx_d       = 8'h00;
            state_d     = StDrain;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
            state_d     = StHunt;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          idx_d = idx_q + 8'd1;
          if (drain_last) begin
            state_d = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    // Timeout only fires in cycles without a capture, so it never races a
    // checksum verdict.
    if (timeout) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
      state_d     = StHunt;
    end
  end

  // Pop decision is made against the next state so no read ever lands in
  // DRAIN, and the pending read blocks back-to-back pops.
  always_comb begin
    rd_d = (state_d != StDrain) && !rx_empty && !rd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHunt;
      rd_q        <= 1'b0;
      cap_q       <= 1'b0;
      len_q       <= 8'h00;
      acc_q       <= 8'h00;
      idx_q       <= 8'h00;
      frame_len_q <= 8'h00;
      err_code_q  <= 2'b00;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      cap_q       <= rd_q;
      len_q       <= len_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      frame_len_q <= frame_len_d;
      err_code_q  <= err_code_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Payload buffer, intentionally not reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[IdxW-1:0]] <= r_data;
    end
  end

  // Outputs
  always_comb begin
    out_valid = (state_q == StDrain);
    out_data  = out_valid ? buf_q[idx_q[IdxW-1:0]] : 8'h00;
    out_last  = out_valid && drain_last;
  end

  assign rd_uart   = rd_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign frame_len = frame_len_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: models the RX FIFO, records DUT
// output events in a monitor, and compares them against expected payload
// queues filled while frames are pushed.
module tb_uart_frame_parser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_len;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo[$];
  logic [8:0] exp_q[$];   // {last, data}
  logic [8:0] obs_q[$];

  int         cyc = 0;
  int         ok_cnt = 0, err_cnt = 0, both_cnt = 0, rd_drain_cnt = 0, valid_cnt = 0;
  int         last_rd_cyc = 0, err_cyc = 0;
  logic [1:0] last_err = 2'b00;
  logic [7:0] last_ok_len = 8'h00;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN       (16),
    .SOF           (8'hA5),
    .TO_BITS       (20),
    .TIMEOUT_CYCLES(20'd50)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .frame_len(frame_len)
  );

  // FIFO model: standard read, data appears the cycle after the pop.
  always @(posedge clk) begin
    logic pop;
    pop = rd_uart;
    cyc++;
    #1;
    if (pop && fifo.size() != 0) r_data = fifo.pop_front();
    rx_empty = (fifo.size() == 0);
  end

  // Event monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
      if (out_valid) valid_cnt++;
      if (frame_ok) begin
        ok_cnt++;
        last_ok_len = frame_len;
      end
      if (frame_err) begin
        err_cnt++;
        last_err = err_code;
        err_cyc  = cyc;
      end
      if (frame_ok && frame_err) both_cnt++;
      if (rd_uart && out_valid) rd_drain_cnt++;
      if (rd_uart) last_rd_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    rx_empty = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic clear_counts();
    ok_cnt = 0; err_cnt = 0; both_cnt = 0; rd_drain_cnt = 0; valid_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    tests++;
    if ({rd_uart, out_valid, out_last, frame_ok, frame_err, err_code, frame_len} !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0",
               {rd_uart, out_valid, out_last, frame_ok, frame_err, err_code, frame_len});
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_good_frame();
    clear_counts();
    out_ready = 1'b1;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
    expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b0); expect_byte(8'h33, 1'b1);
    tick(30);
    tests++;
    if (ok_cnt !== 1 || err_cnt !== 0) begin
      fails++;
      $display("FAIL good_pulses: got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt);
    end
    tests++;
    if (frame_len !== 8'd3 || last_ok_len !== 8'd3) begin
      fails++;
      $display("FAIL good_len: got %0d/%0d want 3", frame_len, last_ok_len);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL good_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL good_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_checksum();
    clear_counts();
    out_ready = 1'b1;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h6A);
    tick(30);
    tests++;
    if (err_cnt !== 1 || last_err !== 2'b10 || ok_cnt !== 0) begin
      fails++;
      $display("FAIL badchk_err: got err=%0d code=%b ok=%0d want 1/10/0", err_cnt, last_err, ok_cnt);
    end
    tests++;
    if (valid_cnt !== 0) begin
      fails++;
      $display("FAIL badchk_novalid: got %0d valid cycles want 0", valid_cnt);
    end
    // Following good frame: 02 01 02, chk 05.
    push(8'hA5); push(8'h02); push(8'h01); push(8'h02); push(8'h05);
    expect_byte(8'h01, 1'b0); expect_byte(8'h02, 1'b1);
    tick(30);
    tests++;
    if (ok_cnt !== 1 || frame_len !== 8'd2) begin
      fails++;
      $display("FAIL badchk_next: got ok=%0d len=%0d want 1/2", ok_cnt, frame_len);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL badchk_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL badchk_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_length();
    logic [7:0] sum;
    clear_counts();
    out_ready = 1'b1;
    push(8'hA5); push(8'h00);
    tick(10);
    tests++;
    if (err_cnt !== 1 || last_err !== 2'b01) begin
      fails++;
      $display("FAIL badlen_zero: got err=%0d code=%b want 1/01", err_cnt, last_err);
    end
    push(8'hA5); push(8'h11);
    tick(10);
    tests++;
    if (err_cnt !== 2 || last_err !== 2'b01) begin
      fails++;
      $display("FAIL badlen_big: got err=%0d code=%b want 2/01", err_cnt, last_err);
    end
    // Maximum legal length: 16 bytes 0..15.
    push(8'hA5); push(8'h10);
    sum = 8'h10;
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      sum = sum + 8'(i);
      expect_byte(8'(i), i == 15);
    end
    push(sum);
    tick(70);
    tests++;
    if (ok_cnt !== 1 || frame_len !== 8'd16 || err_cnt !== 2) begin
      fails++;
      $display("FAIL badlen_max: got ok=%0d len=%0d err=%0d want 1/16/2", ok_cnt, frame_len, err_cnt);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL badlen_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL badlen_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_resync();
    clear_counts();
    out_ready = 1'b1;
    push(8'h00); push(8'hFF); push(8'h5A); push(8'hA5); push(8'h01); push(8'hA5); push(8'hA6);
    expect_byte(8'hA5, 1'b1);
    tick(30);
    tests++;
    if (ok_cnt !== 1 || err_cnt !== 0 || frame_len !== 8'd1) begin
      fails++;
      $display("FAIL resync_pulses: got ok=%0d err=%0d len=%0d want 1/0/1", ok_cnt, err_cnt, frame_len);
    end
    tests++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL resync_byte: got %0d bytes first %h want 1 byte %h",
               obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 9'h0, exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    int waited;
    int unstable;
    clear_counts();
    out_ready = 1'b0;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
    push(8'hA5); push(8'h01); push(8'h42); push(8'h43);
    expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b0); expect_byte(8'h33, 1'b1);
    expect_byte(8'h42, 1'b1);
    waited = 0;
    while (!out_valid && waited < 60) begin
      tick(1);
      waited++;
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL bp_valid_timeout: got out_valid=0 want 1 within 60 cycles");
    end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) unstable++;
      tick(1);
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable);
    end
    for (int i = 0; i < 20; i++) begin
      out_ready = ~out_ready;
      tick(1);
    end
    out_ready = 1'b1;
    tick(30);
    tests++;
    if (rd_drain_cnt !== 0) begin
      fails++;
      $display("FAIL bp_no_rd_in_drain: got %0d want 0", rd_drain_cnt);
    end
    tests++;
    if (ok_cnt !== 2 || both_cnt !== 0) begin
      fails++;
      $display("FAIL bp_pulses: got ok=%0d both=%0d want 2/0", ok_cnt, both_cnt);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL bp_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    int waited;
    clear_counts();
    out_ready = 1'b0;
    push(8'hA5); push(8'h01); push(8'h55); push(8'h56);
    waited = 0;
    while (!out_valid && waited < 40) begin
      tick(1);
      waited++;
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL rstdrain_valid_timeout: got out_valid=0 want 1 within 40 cycles");
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({rd_uart, out_valid, out_last, frame_ok, frame_err, err_code, frame_len, out_data} !== 23'h0) begin
      fails++;
      $display("FAIL rstdrain_outputs: got %h want 0",
               {rd_uart, out_valid, out_last, frame_ok, frame_err, err_code, frame_len, out_data});
    end
    tick(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    obs_q.delete();
    clear_counts();
    push(8'hA5); push(8'h01); push(8'h66); push(8'h67);
    expect_byte(8'h66, 1'b1);
    tick(20);
    tests++;
    if (ok_cnt !== 1 || err_cnt !== 0 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL rstdrain_recover: got ok=%0d err=%0d n=%0d want 1/0/1 byte %h",
               ok_cnt, err_cnt, obs_q.size(), exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    clear_counts();
    out_ready = 1'b1;
    push(8'hA5); push(8'h02); push(8'h11);
    tick(200);
`ifdef UART_FRAME_TIMEOUT_EN
    tests++;
    if (err_cnt !== 1 || last_err !== 2'b11) begin
      fails++;
      $display("FAIL timeout_err: got err=%0d code=%b want 1/11", err_cnt, last_err);
    end
    // Capture of 0x11 is the cycle after its pop; the pulse follows 50 idle cycles.
    tests++;
    if (err_cyc !== last_rd_cyc + 52) begin
      fails++;
      $display("FAIL timeout_cycle: got %0d want %0d", err_cyc, last_rd_cyc + 52);
    end
`else
    tests++;
    if (err_cnt !== 0 || ok_cnt !== 0) begin
      fails++;
      $display("FAIL stall_noerr: got err=%0d ok=%0d want 0/0", err_cnt, ok_cnt);
    end
    push(8'h22); push(8'h35);
    expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b1);
    tick(20);
    tests++;
    if (ok_cnt !== 1 || obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      fails++;
      $display("FAIL stall_resume: got ok=%0d n=%0d want ok=1 bytes %h %h",
               ok_cnt, obs_q.size(), exp_q[0], exp_q[1]);
    end
`endif
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_resync();
    test_backpressure();
    test_reset_mid_drain();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
